// File: rtl/mem_access_pkg.sv
// Shared types for the mem_access load/store unit: opcode encodings, FSM states and data width.
package mem_access_pkg;

  localparam int unsigned SizeW = 32;

  typedef logic [SizeW-1:0] size_t;

  // MIPS primary-opcode encodings of the memory instructions
  typedef enum logic [5:0] {
    OP_LB  = 6'h20,
    OP_LH  = 6'h21,
    OP_LWL = 6'h22,
    OP_LW  = 6'h23,
    OP_LBU = 6'h24,
    OP_LHU = 6'h25,
    OP_LWR = 6'h26,
    OP_SB  = 6'h28,
    OP_SH  = 6'h29,
    OP_SW  = 6'h2B
  } opcode_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StReadData,
    StWrite
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for requests and big-endian extraction of load results.
// LWL/LWR decode is enabled by the MEM_ACCESS_LWLR_EN macro.
module mem_align
  import mem_access_pkg::*;
(
  input  opcode_t     req_op_i,
  input  logic [1:0]  req_off_i,
  input  size_t       req_rt_i,
  output logic        req_valid_o,
  output logic        req_misaligned_o,
  output logic        req_load_o,
  output logic [3:0]  req_be_o,
  output size_t       req_wdata_o,
  input  opcode_t     ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  size_t       ld_rt_i,
  input  size_t       rdata_i,
  output size_t       load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;

  always_comb begin
    req_valid_o      = 1'b0;
    req_misaligned_o = 1'b0;
    req_load_o       = 1'b0;
    req_be_o         = 4'b1111;
    req_wdata_o      = req_rt_i;
    case (req_op_i)
      OP_LB, OP_LBU: begin
        req_valid_o = 1'b1;
        req_load_o  = 1'b1;
      end
      OP_LH, OP_LHU: begin
        req_valid_o      = 1'b1;
        req_load_o       = 1'b1;
        req_misaligned_o = req_off_i[0];
      end
      OP_LW: begin
        req_valid_o      = 1'b1;
        req_load_o       = 1'b1;
        req_misaligned_o = |req_off_i;
      end
`ifdef MEM_ACCESS_LWLR_EN
      OP_LWL, OP_LWR: begin
        req_valid_o = 1'b1;
        req_load_o  = 1'b1;
      end
`endif
      OP_SB: begin
        req_valid_o = 1'b1;
        req_be_o    = 4'b1000 >> req_off_i;
        req_wdata_o = {4{req_rt_i[7:0]}};
      end
      OP_SH: begin
        req_valid_o      = 1'b1;
        req_misaligned_o = req_off_i[0];
        req_be_o         = req_off_i[1] ? 4'b0011 : 4'b1100;
        req_wdata_o      = {2{req_rt_i[15:0]}};
      end
      OP_SW: begin
        req_valid_o      = 1'b1;
        req_misaligned_o = |req_off_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[31:24];
      2'd1:    ld_byte = rdata_i[23:16];
      2'd2:    ld_byte = rdata_i[15:8];
      default: ld_byte = rdata_i[7:0];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    sh_l    = {ld_off_i, 3'b000};
    sh_r    = {~ld_off_i, 3'b000};  // 8*(3-k)
    // LWL/LWR arms stay unreachable unless the request decode admits them
    case (ld_op_i)
      OP_LB:   load_data_o = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data_o = {24'h0, ld_byte};
      OP_LH:   load_data_o = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data_o = {16'h0, ld_half};
      OP_LWL:  load_data_o = (rdata_i << sh_l) | (ld_rt_i & ((32'd1 << sh_l) - 32'd1));
      OP_LWR:  load_data_o = (rdata_i >> sh_r) | (ld_rt_i & ~(32'hFFFF_FFFF >> sh_r));
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store unit bridging a CPU request to an Avalon-MM master port (big-endian lanes).
// Optional LWL/LWR support: define MEM_ACCESS_LWLR_EN.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  opcode_t     opcode_i,
  input  size_t       address_i,
  input  size_t       rt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        addr_err_o,
  output size_t       load_data_o,
  output size_t       avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [3:0]  avm_byteenable_o,
  output size_t       avm_writedata_o,
  input  logic        avm_waitrequest_i,
  input  size_t       avm_readdata_i
);

  mem_state_t state_q, state_d;
  size_t      addr_q, rt_q, wdata_q, load_data_q;
  opcode_t    op_q;
  logic [1:0] off_q;
  logic [3:0] be_q;
  logic       done_q, addr_err_q;

  logic       req_valid, req_misaligned, req_load;
  logic [3:0] req_be;
  size_t      req_wdata, fmt_data;
  logic       idle_start, accept;

  mem_align u_align (
    .req_op_i         (opcode_i),
    .req_off_i        (address_i[1:0]),
    .req_rt_i         (rt_i),
    .req_valid_o      (req_valid),
    .req_misaligned_o (req_misaligned),
    .req_load_o       (req_load),
    .req_be_o         (req_be),
    .req_wdata_o      (req_wdata),
    .ld_op_i          (op_q),
    .ld_off_i         (off_q),
    .ld_rt_i          (rt_q),
    .rdata_i          (avm_readdata_i),
    .load_data_o      (fmt_data)
  );

  assign idle_start = (state_q == StIdle) && start_i && req_valid;
  assign accept     = idle_start && !req_misaligned;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = req_load ? StRead : StWrite;
      StRead:     if (!avm_waitrequest_i) state_d = StReadData;
      StReadData: state_d = StIdle;
      StWrite:    if (!avm_waitrequest_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    avm_read_o  = (state_q == StRead);
    avm_write_o = (state_q == StWrite);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      op_q        <= OP_LB;
      off_q       <= 2'b00;
      rt_q        <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      done_q     <= (state_q == StReadData) || ((state_q == StWrite) && !avm_waitrequest_i);
      addr_err_q <= idle_start && req_misaligned;
      if (accept) begin
        addr_q  <= {address_i[31:2], 2'b00};
        op_q    <= opcode_i;
        off_q   <= address_i[1:0];
        rt_q    <= rt_i;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      if (state_q == StReadData) load_data_q <= fmt_data;
    end
  end

  assign done_o           = done_q;
  assign addr_err_o       = addr_err_q;
  assign load_data_o      = load_data_q;
  assign avm_address_o    = addr_q;
  assign avm_byteenable_o = be_q;
  assign avm_writedata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; LWL/LWR cases follow MEM_ACCESS_LWLR_EN.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  opcode_t     opcode_i;
  logic [31:0] address_i, rt_i;
  logic        busy_o, done_o, addr_err_o;
  logic [31:0] load_data_o, avm_address_o, avm_writedata_o;
  logic        avm_read_o, avm_write_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_waitrequest_i;
  logic [31:0] avm_readdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last run_txn
  int          g_done_cyc, g_err_cyc, g_stb_cyc, g_nrd, g_nwr;
  bit          g_unstable;
  logic [31:0] g_addr, g_wdata, g_load;
  logic [3:0]  g_be;

  mem_access dut (
    .clk               (clk),
    .reset             (reset),
    .start_i           (start_i),
    .opcode_i          (opcode_i),
    .address_i         (address_i),
    .rt_i              (rt_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .addr_err_o        (addr_err_o),
    .load_data_o       (load_data_o),
    .avm_address_o     (avm_address_o),
    .avm_read_o        (avm_read_o),
    .avm_write_o       (avm_write_o),
    .avm_byteenable_o  (avm_byteenable_o),
    .avm_writedata_o   (avm_writedata_o),
    .avm_waitrequest_i (avm_waitrequest_i),
    .avm_readdata_i    (avm_readdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one request at a negedge; cycle N is the one after the Nth rising edge past the start.
  // The slave stalls the first `waits` strobe cycles and returns rdata the cycle after acceptance.
  task automatic run_txn(input opcode_t op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rdata, input int waits, input bit poke);
    int nstb = 0;
    bit acc_prev = 1'b0;
    g_done_cyc = 0; g_err_cyc = 0; g_stb_cyc = 0; g_nrd = 0; g_nwr = 0; g_unstable = 1'b0;
    g_load = 'x;
    opcode_i = op; address_i = addr; rt_i = rt; start_i = 1'b1;
    avm_waitrequest_i = 1'b0; avm_readdata_i = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start_i = poke && (cyc == 1);
      if (poke && cyc == 1) begin
        opcode_i = OP_SW; address_i = 32'h0000_7000;
      end
      avm_readdata_i = acc_prev ? rdata : 32'hDEAD_BEEF;
      if (avm_read_o || avm_write_o) begin
        nstb++;
        if (nstb == 1) begin
          g_stb_cyc = cyc; g_addr = avm_address_o; g_be = avm_byteenable_o;
          g_wdata = avm_writedata_o;
        end else if (avm_address_o !== g_addr || avm_byteenable_o !== g_be ||
                     avm_writedata_o !== g_wdata) begin
          g_unstable = 1'b1;
        end
        if (avm_read_o)  g_nrd++;
        if (avm_write_o) g_nwr++;
      end
      avm_waitrequest_i = (avm_read_o || avm_write_o) && (nstb <= waits);
      acc_prev = avm_read_o && !avm_waitrequest_i;
      if (addr_err_o && g_err_cyc == 0) g_err_cyc = cyc;
      if (done_o) begin
        g_done_cyc = cyc; g_load = load_data_o;
        break;
      end
    end
    start_i = 1'b0; avm_waitrequest_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; opcode_i = OP_LB; address_i = '0; rt_i = '0;
    avm_waitrequest_i = 1'b0; avm_readdata_i = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, addr_err_o, avm_read_o, avm_write_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy_o, done_o, addr_err_o, avm_read_o, avm_write_o});
    end
    n_checks++;
    if (avm_byteenable_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_be: got %b expected 0000", avm_byteenable_o);
    end
    n_checks++;
    if ({load_data_o, avm_address_o, avm_writedata_o} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected zeros",
               load_data_o, avm_address_o, avm_writedata_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    run_txn(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1'b0);
    n_checks++;
    if (g_stb_cyc !== 1 || g_nwr !== 1 || g_nrd !== 0) begin
      n_fail++; $display("FAIL sb_strobe: got cyc %0d wr %0d rd %0d expected 1 1 0",
                         g_stb_cyc, g_nwr, g_nrd);
    end
    n_checks++;
    if (g_addr !== 32'h0000_1000 || g_be !== 4'b0001 || g_wdata !== 32'hABAB_ABAB) begin
      n_fail++; $display("FAIL sb_bus: got %h %b %h expected 00001000 0001 abababab",
                         g_addr, g_be, g_wdata);
    end
    n_checks++;
    if (g_done_cyc !== 2) begin
      n_fail++; $display("FAIL sb_done_cycle: got %0d expected 2", g_done_cyc);
    end
    run_txn(OP_SH, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 0, 1'b0);
    n_checks++;
    if (g_addr !== 32'h0000_2000 || g_be !== 4'b0011 || g_wdata !== 32'hBEEF_BEEF) begin
      n_fail++; $display("FAIL sh_bus: got %h %b %h expected 00002000 0011 beefbeef",
                         g_addr, g_be, g_wdata);
    end
    run_txn(OP_SH, 32'h0000_2000, 32'h1234_BEEF, 32'h0, 0, 1'b0);
    n_checks++;
    if (g_be !== 4'b1100) begin
      n_fail++; $display("FAIL sh_be_k0: got %b expected 1100", g_be);
    end
    run_txn(OP_SW, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
    n_checks++;
    if (g_be !== 4'b1111 || g_wdata !== 32'hCAFE_F00D || g_unstable) begin
      n_fail++; $display("FAIL sw_bus: got %b %h unstable %0d expected 1111 cafef00d 0",
                         g_be, g_wdata, g_unstable);
    end
    n_checks++;
    if (g_done_cyc !== 3 || g_nwr !== 2) begin
      n_fail++; $display("FAIL sw_wait: got done %0d wr %0d expected 3 2", g_done_cyc, g_nwr);
    end
  endtask

  task automatic test_load();
    run_txn(OP_LB, 32'h0000_2001, 32'h0, 32'h12F4_5678, 2, 1'b0);
    n_checks++;
    if (g_load !== 32'hFFFF_FFF4 || g_done_cyc !== 5) begin
      n_fail++; $display("FAIL lb_wait: got %h cyc %0d expected fffffff4 5", g_load, g_done_cyc);
    end
    n_checks++;
    if (g_nrd !== 3 || g_unstable || g_be !== 4'b1111 || g_addr !== 32'h0000_2000) begin
      n_fail++; $display("FAIL lb_bus: got rd %0d unstable %0d be %b addr %h",
                         g_nrd, g_unstable, g_be, g_addr);
    end
    run_txn(OP_LBU, 32'h0000_2001, 32'h0, 32'h12F4_5678, 2, 1'b0);
    n_checks++;
    if (g_load !== 32'h0000_00F4) begin
      n_fail++; $display("FAIL lbu: got %h expected 000000f4", g_load);
    end
    run_txn(OP_LH, 32'h0000_3002, 32'h0, 32'hAAAA_8001, 0, 1'b0);
    n_checks++;
    if (g_load !== 32'hFFFF_8001 || g_done_cyc !== 3) begin
      n_fail++; $display("FAIL lh: got %h cyc %0d expected ffff8001 3", g_load, g_done_cyc);
    end
    run_txn(OP_LHU, 32'h0000_3000, 32'h0, 32'h8001_AAAA, 0, 1'b0);
    n_checks++;
    if (g_load !== 32'h0000_8001) begin
      n_fail++; $display("FAIL lhu: got %h expected 00008001", g_load);
    end
    run_txn(OP_LW, 32'h0000_3004, 32'h0, 32'h89AB_CDEF, 0, 1'b0);
    n_checks++;
    if (g_load !== 32'h89AB_CDEF) begin
      n_fail++; $display("FAIL lw: got %h expected 89abcdef", g_load);
    end
    n_checks++;
    if (load_data_o !== 32'h89AB_CDEF) begin
      n_fail++; $display("FAIL load_hold: got %h expected 89abcdef", load_data_o);
    end
  endtask

  task automatic test_misaligned();
    run_txn(OP_LW, 32'h0000_3002, 32'h0, 32'h0, 0, 1'b0);
    n_checks++;
    if (g_err_cyc !== 1 || g_nrd + g_nwr !== 0 || g_done_cyc !== 0) begin
      n_fail++; $display("FAIL lw_misaligned: got err %0d strobes %0d done %0d expected 1 0 0",
                         g_err_cyc, g_nrd + g_nwr, g_done_cyc);
    end
    run_txn(OP_SH, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);
    n_checks++;
    if (g_err_cyc !== 1 || g_nrd + g_nwr !== 0 || g_done_cyc !== 0) begin
      n_fail++; $display("FAIL sh_misaligned: got err %0d strobes %0d done %0d expected 1 0 0",
                         g_err_cyc, g_nrd + g_nwr, g_done_cyc);
    end
  endtask

  task automatic test_nonmem();
    run_txn(opcode_t'(6'h0F), 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);
    n_checks++;
    if (g_err_cyc !== 0 || g_nrd + g_nwr !== 0 || g_done_cyc !== 0) begin
      n_fail++; $display("FAIL nonmem: got err %0d strobes %0d done %0d expected 0 0 0",
                         g_err_cyc, g_nrd + g_nwr, g_done_cyc);
    end
  endtask

  task automatic test_lwlr();
`ifdef MEM_ACCESS_LWLR_EN
    run_txn(OP_LWL, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0);
    n_checks++;
    if (g_load !== 32'hBBCC_DD44 || g_be !== 4'b1111 || g_addr !== 32'h0000_4000) begin
      n_fail++; $display("FAIL lwl: got %h %b %h expected bbccdd44 1111 00004000",
                         g_load, g_be, g_addr);
    end
    run_txn(OP_LWR, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0);
    n_checks++;
    if (g_load !== 32'h1122_AABB) begin
      n_fail++; $display("FAIL lwr: got %h expected 1122aabb", g_load);
    end
`else
    run_txn(OP_LWL, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0);
    n_checks++;
    if (g_err_cyc !== 0 || g_nrd + g_nwr !== 0 || g_done_cyc !== 0) begin
      n_fail++; $display("FAIL lwl_disabled: got err %0d strobes %0d done %0d expected 0 0 0",
                         g_err_cyc, g_nrd + g_nwr, g_done_cyc);
    end
`endif
  endtask

  task automatic test_back_to_back();
    run_txn(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1'b0);
    // Start issued in the done cycle of the store
    run_txn(OP_LW, 32'h0000_3004, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    n_checks++;
    if (g_done_cyc !== 3 || g_load !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL b2b_load: got cyc %0d %h expected 3 0badf00d", g_done_cyc, g_load);
    end
    run_txn(OP_LW, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 2, 1'b1);
    n_checks++;
    if (g_nwr !== 0 || g_done_cyc !== 5 || g_load !== 32'h1357_9BDF) begin
      n_fail++; $display("FAIL busy_start_ignored: got wr %0d cyc %0d %h expected 0 5 13579bdf",
                         g_nwr, g_done_cyc, g_load);
    end
  endtask

  task automatic test_reset_mid();
    opcode_i = OP_LB; address_i = 32'h0000_2000; start_i = 1'b1; avm_waitrequest_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if (avm_read_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_read: got %b expected 1", avm_read_o);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({avm_read_o, busy_o, done_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_drop: got %b expected 000", {avm_read_o, busy_o, done_o});
    end
    reset = 1'b0; avm_waitrequest_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_nodone: got %b%b expected 00", done_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_nonmem();
    test_lwlr();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have no parameters; widths come from the codes package (size_t = 32 bits).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request strobe, sampled only in IDLE.
REQ-005 opcode_i  input  opcode_t  load/store opcode of the request.
REQ-006 address_i  input  32  byte effective address from the ALU.
REQ-007 rt_i  input  32  store data / LWL-LWR merge source.
REQ-008 busy_o  output  1  high while a transaction is in flight.
REQ-009 done_o  output  1  one-cycle completion pulse.
REQ-010 addr_err_o  output  1  one-cycle misaligned-access pulse.
REQ-011 load_data_o  output  32  formatted load result, held until next load completes.
REQ-012 avm_address_o  output  32  word-aligned bus address {addr[31:2],2'b00}.
REQ-013 avm_read_o, avm_write_o  output  1 each  Avalon-MM strobes.
REQ-014 avm_byteenable_o  output  4  byte lanes; bit 3 = byte offset 0 (big-endian).
REQ-015 avm_writedata_o  output  32  lane-replicated store data.
REQ-016 avm_waitrequest_i  input  1  slave stall; avm_readdata_i  input  32  valid the cycle after read acceptance.

Function
REQ-017 FSM states SHALL be IDLE, READ, READ_DATA, WRITE.
REQ-018 IDLE + start_i + supported aligned opcode SHALL latch address, opcode, offset, rt_i, byteenable and writedata, then enter READ (loads) or WRITE (stores).
REQ-019 start_i with a non-memory opcode SHALL be ignored: no bus activity, no pulse.
REQ-020 Misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL perform no bus access, pulse addr_err_o on the next cycle, and leave done_o low.
REQ-021 READ/WRITE SHALL hold the strobe, address, byteenable and writedata stable while avm_waitrequest_i=1.
REQ-022 READ with waitrequest=0 SHALL go to READ_DATA; READ_DATA SHALL register the formatted load_data_o, return to IDLE, and pulse done_o on the following cycle.
REQ-023 WRITE with waitrequest=0 SHALL return to IDLE and pulse done_o on the following cycle.
REQ-024 Zero-wait latency SHALL be: start sampled at edge 0, strobe in cycle 1, done_o in cycle 3 for a load and cycle 2 for a store; each wait cycle adds one cycle.
REQ-025 busy_o SHALL be high in every non-IDLE state; start_i while busy SHALL be ignored; start_i in the done_o cycle SHALL be accepted.
REQ-026 Stores: SB SHALL drive data {4{rt[7:0]}} with be 4'b1000>>k (k = addr[1:0]); SH SHALL drive {2{rt[15:0]}} with be 1100 (k=0) or 0011 (k=2); SW SHALL drive rt with be 1111.
REQ-027 Loads SHALL read with be 1111; LB/LBU SHALL extract readdata[31-8k -: 8] and sign/zero-extend; LH/LHU SHALL extract [31:16] (k=0) or [15:0] (k=2) and sign/zero-extend; LW SHALL pass the word through.

Reset
REQ-028 Reset SHALL force IDLE and drive busy_o, done_o, addr_err_o, avm_read_o, avm_write_o=0, avm_byteenable_o=4'b0000, and load_data_o, avm_address_o, avm_writedata_o=0.
REQ-029 Reset mid-transaction SHALL drop the strobes on the next edge and emit no done_o.

Configuration
REQ-030 With MEM_ACCESS_LWLR_EN defined, LWL/LWR SHALL be accepted at any alignment and read with be 1111.
REQ-031 LWL SHALL return (word<<8k) | (rt & ((1<<8k)-1)).
REQ-032 LWR SHALL return (word>>8(3-k)) | (rt & ~(32'hFFFFFFFF>>8(3-k))).
REQ-033 Without MEM_ACCESS_LWLR_EN, LWL/LWR SHALL be treated as non-memory opcodes per REQ-019.

Structure
REQ-034 The codes package SHALL hold opcode_t (OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW) and the enum mem_state_t.
REQ-035 Lane steering and extraction SHALL live in one combinational sub-module, mem_align; the FSM stays in mem_access.

Verification
REQ-036 SB addr 0x1003, rt 0x000000AB, no wait -> write cycle 1, address 0x1000, be 0001, data 0xABABABAB, done_o cycle 2.
REQ-037 LB addr 0x2001, readdata 0x12F45678, 2 wait cycles -> load_data_o 0xFFFFFFF4, done_o cycle 5; LBU same -> 0x000000F4.
REQ-038 LH addr 0x3002, readdata 0xAAAA8001 -> 0xFFFF8001; LW addr 0x3002 -> addr_err_o pulse, no strobe, no done_o.
REQ-039 Reset asserted during READ with waitrequest=1 -> avm_read_o 0 next cycle, busy_o 0, no done_o.
REQ-040 With the macro: LWL addr 0x4001, rt 0x11223344, word 0xAABBCCDD -> 0xBBCCDD44; without it -> no bus activity.
